// File: rtl/sha3_pkg.sv
// Shared parameters and types for the SHA-3 digest output stage.
package sha3_pkg;

  localparam int LANE_W       = 64;
  localparam int IX_W         = 24;
  localparam int DIGEST_LANES = 4;
  localparam int FIFO_DEPTH   = 2;

  // Derived widths for the digest FIFO and the word counter.
  localparam int FIFO_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FIFO_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int LANE_SEL_W   = $clog2(DIGEST_LANES);

  // Serializer state: IDLE drives no beat, SEND presents one digest word.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // One queued digest: message index plus the four digest lanes.
  typedef struct packed {
    logic [IX_W-1:0]                          ix;
    logic [DIGEST_LANES-1:0][LANE_W-1:0]      lane;
  } digest_entry_t;

endpackage

// File: rtl/sha3_digest_fifo.sv
// Small FIFO of captured digests; head is read straight from storage.
module sha3_digest_fifo
  import sha3_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  digest_entry_t         wr_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output digest_entry_t         head,
  output logic [FIFO_CNT_W-1:0] count
);

  digest_entry_t         mem_r [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_r;
  logic [FIFO_PTR_W-1:0] rd_ptr_r;
  logic [FIFO_CNT_W-1:0] count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Pointer advance with explicit wrap so non-power-of-two depths also work.
  function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] p);
    if (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) begin
      return {FIFO_PTR_W{1'b0}};
    end else begin
      return p + FIFO_PTR_W'(1);
    end
  endfunction

  assign full      = (count_r == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty     = (count_r == {FIFO_CNT_W{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok_s = push && (!full || pop_ok_s);

  // Digest storage; contents are don't-care until the count marks them valid.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      mem_r[wr_ptr_r] <= wr_entry;
    end
  end

  // Pointers and occupancy; reset empties the FIFO and discards any push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {FIFO_PTR_W{1'b0}};
      rd_ptr_r <= {FIFO_PTR_W{1'b0}};
      count_r  <= {FIFO_CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + FIFO_CNT_W'(1);
        2'b01:   count_r <= count_r - FIFO_CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sha3_digest_out.sv
// Captures the 256-bit digest from the permuted Keccak state and streams it
// out as four 64-bit words with downstream stall support.
module sha3_digest_out
  import sha3_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pushin,
  input  logic [IX_W-1:0]           dix,
  input  logic [4:0][4:0][LANE_W-1:0] din,
  input  logic                      stopin,
  output logic                      pushout,
  output logic [IX_W-1:0]           doutix,
  output logic [LANE_W-1:0]         dout,
  output logic                      lastout,
  output logic                      overflow
);

  localparam logic [LANE_SEL_W-1:0] LAST_WORD = LANE_SEL_W'(DIGEST_LANES - 1);

  digest_entry_t         cap_s;
  digest_entry_t         head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FIFO_CNT_W-1:0] fifo_count_s;
  logic                  beat_s;
  logic                  last_beat_s;
  logic                  more_s;
  logic                  unused_lanes_s;

  ser_state_t            state_r;
  logic [LANE_SEL_W-1:0] wcnt_r;
  logic                  pushout_r;
  logic                  overflow_r;

  // Only the first four lanes of row 0 form the digest; the rest is dropped.
  always_comb begin
    cap_s.ix = dix;
    for (int k = 0; k < DIGEST_LANES; k++) begin
      cap_s.lane[k] = din[0][k];
    end
  end

  assign unused_lanes_s = ^{din[4:1], din[0][4]};

  assign beat_s      = pushout_r && !stopin;
  assign last_beat_s = beat_s && (wcnt_r == LAST_WORD);
  // After the final pop, SEND continues if an older entry remains or a new one lands now.
  assign more_s      = (fifo_count_s > FIFO_CNT_W'(1)) || pushin;

  sha3_digest_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushin),
    .wr_entry (cap_s),
    .pop      (last_beat_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .head     (head_s),
    .count    (fifo_count_s)
  );

  // Serializer FSM with word counter, registered valid and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wcnt_r     <= {LANE_SEL_W{1'b0}};
      pushout_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (pushin && fifo_full_s && !last_beat_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          wcnt_r <= {LANE_SEL_W{1'b0}};
          if (pushin || !fifo_empty_s) begin
            state_r   <= ST_SEND;
            pushout_r <= 1'b1;
          end else begin
            pushout_r <= 1'b0;
          end
        end
        ST_SEND: begin
          if (last_beat_s) begin
            wcnt_r <= {LANE_SEL_W{1'b0}};
            if (more_s) begin
              pushout_r <= 1'b1;
            end else begin
              state_r   <= ST_IDLE;
              pushout_r <= 1'b0;
            end
          end else if (beat_s) begin
            wcnt_r <= wcnt_r + LANE_SEL_W'(1);
          end else begin
            wcnt_r <= wcnt_r;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          wcnt_r    <= {LANE_SEL_W{1'b0}};
          pushout_r <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come only from registered state and the registered FIFO head.
  assign pushout  = pushout_r;
  assign overflow = overflow_r;
  assign lastout  = pushout_r && (wcnt_r == LAST_WORD);
  assign doutix   = pushout_r ? head_s.ix : {IX_W{1'b0}};
  assign dout     = pushout_r ? head_s.lane[wcnt_r] : {LANE_W{1'b0}};

endmodule

// File: tb/tb_sha3_digest_out.sv
// Directed plus randomized-stall bench for sha3_digest_out with a beat scoreboard.
module tb_sha3_digest_out;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   pushin;
  logic [23:0]            dix;
  logic [4:0][4:0][63:0]  din;
  logic                   stopin;
  logic                   pushout;
  logic [23:0]            doutix;
  logic [63:0]            dout;
  logic                   lastout;
  logic                   overflow;

  typedef struct packed {
    logic [23:0] ix;
    logic [63:0] d;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  logic  exp_ovf = 1'b0;

  sha3_digest_out dut (
    .clk      (clk),
    .reset    (reset),
    .pushin   (pushin),
    .dix      (dix),
    .din      (din),
    .stopin   (stopin),
    .pushout  (pushout),
    .doutix   (doutix),
    .dout     (dout),
    .lastout  (lastout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one digest; pattern=1 gives lanes base*(k+1), else random lanes.
  task automatic load(input logic [23:0] ix, input logic [63:0] base, input bit pattern);
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        din[x][y] = {$urandom, $urandom};
      end
    end
    if (pattern) begin
      for (int k = 0; k < 4; k++) begin
        din[0][k] = base * 64'(k + 1);
      end
    end
    dix    = ix;
    pushin = 1'b1;
  endtask

  // Compare this cycle's outputs with the model, update model, advance one clock.
  task automatic step();
    logic  exp_valid;
    beat_t h;
    if (!reset) begin
      exp_valid = (sb.size() > 0);
      chk("pushout", 64'(pushout), 64'(exp_valid));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      if (exp_valid) begin
        h = sb[0];
        chk("dout", dout, h.d);
        chk("doutix", 64'(doutix), 64'(h.ix));
        chk("lastout", 64'(lastout), 64'(h.last));
        if (!stopin) begin
          void'(sb.pop_front());
        end
      end
      if (pushin) begin
        if ((sb.size() + 3) / 4 >= 2) begin
          exp_ovf = 1'b1;
        end else begin
          for (int k = 0; k < 4; k++) begin
            sb.push_back('{ix: dix, d: din[0][k], last: (k == 3)});
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      sb.delete();
      exp_ovf = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pushout"}, 64'(pushout), 64'd0);
    chk({tag, "_dout"}, dout, 64'd0);
    chk({tag, "_doutix"}, 64'(doutix), 64'd0);
    chk({tag, "_lastout"}, 64'(lastout), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    int budget;
    reset  = 1'b1;
    pushin = 1'b0;
    stopin = 1'b0;
    dix    = 24'd0;
    din    = '0;
    step();
    load(24'h00ABCD, 64'h0, 1'b0);
    step();
    pushin = 1'b0;
    reset  = 1'b0;
    check_zero("reset");

    // Single digest, no stall: beats on the four cycles after pushin.
    repeat (3) step();
    load(24'h000005, 64'h1111_1111_1111_1111, 1'b1);
    step();
    pushin = 1'b0;
    repeat (6) step();

    // Back-to-back digests four cycles apart: no bubble between them.
    load(24'h000001, 64'h0, 1'b0);
    step();
    pushin = 1'b0;
    repeat (3) step();
    load(24'h000002, 64'h0, 1'b0);
    step();
    pushin = 1'b0;
    repeat (8) step();

    // Stall on lane 1 for four cycles.
    load(24'h000009, 64'h0101_0101_0101_0101, 1'b1);
    step();
    pushin = 1'b0;
    step();
    stopin = 1'b1;
    repeat (4) step();
    stopin = 1'b0;
    repeat (5) step();

    // Overflow: three pushes while stalled, the third is dropped.
    stopin = 1'b1;
    load(24'h000001, 64'h0, 1'b0);
    step();
    load(24'h000002, 64'h0, 1'b0);
    step();
    load(24'h000003, 64'h0, 1'b0);
    step();
    pushin = 1'b0;
    repeat (3) step();
    chk("ovf_set", 64'(overflow), 64'd1);
    stopin = 1'b0;
    repeat (10) step();
    chk("ovf_sticky", 64'(overflow), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_zero("ovf_clear");

    // Full FIFO accepts a push on the final-word pop cycle.
    load(24'h000001, 64'h0, 1'b0);
    step();
    load(24'h000002, 64'h0, 1'b0);
    step();
    pushin = 1'b0;
    repeat (2) step();
    load(24'h000003, 64'h0, 1'b0);
    step();
    pushin = 1'b0;
    repeat (10) step();
    chk("full_pop_ovf", 64'(overflow), 64'd0);

    // Reset after lane 1 aborts the digest; pushin during reset is ignored.
    load(24'h000007, 64'h0, 1'b0);
    step();
    pushin = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    load(24'h000008, 64'h0, 1'b0);
    step();
    reset  = 1'b0;
    pushin = 1'b0;
    check_zero("abort");
    repeat (4) step();

    // Random stall and push traffic against the scoreboard.
    repeat (200) begin
      stopin = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        load(24'($urandom), 64'h0, 1'b0);
      end else begin
        pushin = 1'b0;
      end
      step();
    end
    pushin = 1'b0;
    stopin = 1'b0;
    budget = 40;
    while (sb.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha3_digest_out.md
SHA3_DIGEST_OUT -- requirements
Module: sha3_digest_out

Interface
REQ-001 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 Port: pushin  input  1  permuted-state valid from upstream pipeline stage; no backpressure upstream.
REQ-004 Port: dix  input  24  message index accompanying din.
REQ-005 Port: din  input  [4:0][4:0][63:0]  1600-bit Keccak state; lane din[0][k] = digest lane k.
REQ-006 Port: stopin  input  1  downstream stall; word not consumed while high.
REQ-007 Port: pushout  output  1  dout/doutix/lastout valid.
REQ-008 Port: doutix  output  24  message index of current digest word.
REQ-009 Port: dout  output  64  current digest word.
REQ-010 Port: lastout  output  1  high on fourth (final) word of a digest.
REQ-011 Port: overflow  output  1  sticky flag, digest dropped.

Function
REQ-012 Digest capture SHALL take lanes din[0][0], din[0][1], din[0][2], din[0][3] (256 bits) plus dix when pushin is high; other 21 lanes SHALL be discarded.
REQ-013 Captured entries SHALL go into a 2-entry FIFO (entry = 24-bit ix + 256-bit digest), in arrival order.
REQ-014 Serializer states: IDLE (pushout=0), SEND (pushout=1); 2-bit word counter wcnt.
REQ-015 IDLE -> SEND on the cycle after FIFO becomes non-empty; earliest pushout is cycle N+1 for pushin at cycle N (empty FIFO, idle).
REQ-016 In SEND, dout SHALL equal head-entry lane wcnt, doutix SHALL equal head ix, lastout SHALL equal (wcnt==3).
REQ-017 Beat accepted when pushout=1 and stopin=0; wcnt increments by 1 per accepted beat; outputs SHALL hold stable while stopin=1.
REQ-018 On accepted beat with wcnt==3: head entry popped, wcnt -> 0; SEND held if another entry remains (no idle bubble), else -> IDLE.
REQ-019 Push with FIFO full and no pop that cycle: digest SHALL be dropped, FIFO contents unchanged, overflow set to 1 until reset.
REQ-020 Push with FIFO full on the same cycle as final-word pop: push SHALL be accepted, no overflow.
REQ-021 Push and pop on same cycle with one entry: occupancy stays 1, new entry becomes head after pop.
REQ-022 Word order on dout: lane 0, 1, 2, 3; no word skipped or repeated regardless of stopin pattern.

Reset
REQ-023 While reset=1 at a clock edge: pushout=0, doutix=0, dout=0, lastout=0, overflow=0, FIFO empty, wcnt=0, state IDLE.
REQ-024 Reset mid-digest SHALL abort the digest; no remaining words emitted after reset deasserts.
REQ-025 pushin asserted during a reset cycle SHALL be ignored.

Structure
REQ-026 Shared package sha3_pkg SHALL hold LANE_W=64, IX_W=24, DIGEST_LANES=4, FIFO_DEPTH=2, the state typedef, and the digest-entry struct typedef.
REQ-027 FIFO SHALL be a sub-module sha3_digest_fifo (push, pop, full, empty, head, count); serializer FSM in sha3_digest_out.
REQ-028 All outputs SHALL be registered or driven directly from registered FIFO head plus wcnt; no combinational path from pushin to outputs.

Verification
REQ-029 Single digest, stopin=0: pushin at cycle 10, dix=0x000005, din[0][k]=0x1111_1111_1111_1111*(k+1) -> pushout cycles 11-14, dout=0x11..11,0x22..22,0x33..33,0x44..44, doutix=5, lastout only at cycle 14.
REQ-030 Back-to-back: pushin ix=1 at cycle 10 and ix=2 at cycle 14, stopin=0 -> 8 consecutive pushout beats, ix 1 then 2, no bubble.
REQ-031 Stall: stopin=1 for cycles 12-15 during digest -> dout frozen at lane 1 through 15, lane 2 at 16, total 4 distinct words.
REQ-032 Overflow: stopin held 1, pushin ix=1,2,3 on consecutive cycles -> ix 3 dropped, overflow=1; after release, only ix 1 and 2 emitted; overflow stays 1.
REQ-033 Full + final pop: FIFO full, final word of ix 1 accepted in same cycle as pushin ix 3 -> overflow stays 0, order 2 then 3.
REQ-034 Reset mid-digest after lane 1 -> next cycle all outputs 0, no further beats until new pushin.
